// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl: job sequencer for an add/subtract accumulator.
//
// A job carries an initial value, an operation and an operand count.
// The sequencer accepts up to one operand per cycle over a valid/ready
// handshake. It then returns the final result with the carry and the
// sticky signed-overflow flag over a second valid/ready handshake.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start             job request, sampled only while idle
//   op_sub            job operation (0 = add, 1 = subtract), latched at start
//   count             operand count, latched at start (0 = no operands)
//   init              initial accumulator value, latched at start
//   busy              high whenever a job is in flight or its result is pending
//   opnd_valid/opnd   operand stream in
//   opnd_ready        high while operands are being consumed
//   res_valid         result available
//   res_ready         result consumer ready
//   result            accumulator value, held while res_valid and afterwards
//   carry             carry out of the MSB from the last operation
//   ovr               sticky signed overflow across the job
module acc_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] init,
    output logic             busy,
    input  logic             opnd_valid,
    input  logic [WIDTH-1:0] opnd,
    output logic             opnd_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovr
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] remaining;
    logic             sub_q;
    logic [WIDTH-1:0] acc;

    // Datapath: subtraction is acc + ~opnd + 1, so the +1 rides in as carry-in.
    logic [WIDTH-1:0] opnd_eff;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] sum_low;
    logic             c_out;
    logic             c_msb;
    logic             step_ovr;
    logic             take_opnd;

    assign opnd_eff = sub_q ? ~opnd : opnd;
    assign sum_full = {1'b0, acc} + {1'b0, opnd_eff} + {{WIDTH{1'b0}}, sub_q};
    // Sum of the lower WIDTH-1 bits; its top bit is the carry into the MSB.
    assign sum_low  = {1'b0, acc[WIDTH-2:0]} + {1'b0, opnd_eff[WIDTH-2:0]}
                    + {{(WIDTH-1){1'b0}}, sub_q};
    assign c_out    = sum_full[WIDTH];
    assign c_msb    = sum_low[WIDTH-1];
    assign step_ovr = c_out ^ c_msb;

    // opnd_ready is a registered copy of (state == RUN), so this matches the
    // handshake seen externally.
    assign take_opnd = (state == RUN) && opnd_valid;

    assign result = acc;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (take_opnd && (remaining == CNT_W'(1))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state and registered, so
    // no input reaches an output combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            opnd_ready <= 1'b0;
            res_valid  <= 1'b0;
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt != IDLE);
            opnd_ready <= (state_nxt == RUN);
            res_valid  <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            carry     <= 1'b0;
            ovr       <= 1'b0;
            remaining <= '0;
            sub_q     <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                sub_q     <= op_sub;
                acc       <= init;
                remaining <= count;
                carry     <= 1'b0;
                ovr       <= 1'b0;
            end else if (take_opnd) begin
                acc       <= sum_full[WIDTH-1:0];
                carry     <= c_out;
                ovr       <= ovr | step_ovr;
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
module tb_acc_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       op_sub = 1'b0;
    logic [3:0] count = '0;
    logic [7:0] init = '0;
    logic       opnd_valid = 1'b0;
    logic [7:0] opnd = '0;
    logic       res_ready = 1'b0;
    logic       busy, opnd_ready, res_valid, carry, ovr;
    logic [7:0] result;

    int checks = 0;
    int errors = 0;

    logic [7:0] ops [16];

    acc_seq_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_sub     (op_sub),
        .count      (count),
        .init       (init),
        .busy       (busy),
        .opnd_valid (opnd_valid),
        .opnd       (opnd),
        .opnd_ready (opnd_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .result     (result),
        .carry      (carry),
        .ovr        (ovr)
    );

    always #5 clk = ~clk;

    // Reference model: job phase (0 idle, 1 consuming, 2 result pending),
    // operands left, and the result computed with plain integer arithmetic.
    int m_phase = 0;
    int m_rem   = 0;
    int m_acc   = 0;
    bit m_c     = 0;
    bit m_o     = 0;
    bit m_sub   = 0;

    function automatic int to_signed8(input int v);
        return (v > 127) ? v - 256 : v;
    endfunction

    task automatic model_apply(input int b);
        int s, sv;
        if (!m_sub) begin
            s  = m_acc + b;
            sv = to_signed8(m_acc) + to_signed8(b);
        end else begin
            s  = m_acc + (255 - b) + 1;
            sv = to_signed8(m_acc) - to_signed8(b);
        end
        m_c   = (s > 255);
        m_acc = s % 256;
        if (sv > 127 || sv < -128) m_o = 1;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0; m_rem = 0; m_acc = 0; m_c = 0; m_o = 0; m_sub = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_acc = int'(init); m_sub = op_sub; m_rem = int'(count);
                    m_c = 0; m_o = 0;
                    m_phase = (count == 0) ? 2 : 1;
                end
                1: if (opnd_valid) begin
                    model_apply(int'(opnd));
                    m_rem--;
                    if (m_rem == 0) m_phase = 2;
                end
                default: if (res_ready) m_phase = 0;
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("busy",       int'(busy),       int'(m_phase != 0));
        chk("opnd_ready", int'(opnd_ready), int'(m_phase == 1));
        chk("res_valid",  int'(res_valid),  int'(m_phase == 2));
        chk("result",     int'(result),     m_acc);
        chk("carry",      int'(carry),      int'(m_c));
        chk("ovr",        int'(ovr),        int'(m_o));
    end

    task automatic cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] iv, input logic s, input int cnt);
        int i = 0;
        while (busy && i < 64) begin cycle(); i++; end
        chk("start_wait_idle", int'(busy), 0);
        start = 1; init = iv; op_sub = s; count = cnt[3:0];
        cycle();
        // Scramble the descriptor so any failure to latch shows up.
        start = 0; init = 8'($urandom); op_sub = 1'($urandom); count = 4'($urandom);
    endtask

    task automatic feed(input int n, input logic [31:0] pat, input int patlen, input bit glitch);
        int idx = 0;
        int cyc = 0;
        bit v;
        while (idx < n && cyc < 100) begin
            v = (patlen == 0) ? 1'b1 : pat[cyc % patlen];
            opnd_valid = v;
            opnd = v ? ops[idx] : 8'($urandom);
            if (glitch) begin
                start = cyc[0]; init = 8'($urandom); count = 4'($urandom);
            end
            if (v && opnd_ready) idx++;
            cyc++;
            cycle();
        end
        opnd_valid = 0; start = 0; opnd = 8'($urandom);
        chk("feed_consumed", idx, n);
    endtask

    task automatic collect(input string name, input bit immediate,
                           input logic [7:0] er, input bit ec, input bit eo,
                           input int hold, input bit glitch);
        int i = 0;
        res_ready = 0;
        if (immediate) chk({name, "_latency"}, int'(res_valid), 1);
        while (!res_valid && i < 64) begin cycle(); i++; end
        chk({name, "_valid"},  int'(res_valid), 1);
        chk({name, "_result"}, int'(result), int'(er));
        chk({name, "_carry"},  int'(carry), int'(ec));
        chk({name, "_ovr"},    int'(ovr), int'(eo));
        for (int h = 0; h < hold; h++) begin
            if (glitch) begin start = 1; init = 8'($urandom); count = 4'($urandom); end
            cycle();
            chk({name, "_hold_valid"},  int'(res_valid), 1);
            chk({name, "_hold_result"}, int'(result), int'(er));
        end
        start = 0;
        res_ready = 1;
        cycle();
        res_ready = 0;
        chk({name, "_idle_after"}, int'(busy), 0);
    endtask

    initial begin
        cycle();
        chk("reset_busy",   int'(busy), 0);
        chk("reset_result", int'(result), 0);
        cycle();
        rst = 1;
        cycle();

        // Add, back-to-back operands.
        ops[0] = 8'h01; ops[1] = 8'h02; ops[2] = 8'h03;
        start_job(8'h10, 1'b0, 3);
        chk("add_first_ready", int'(opnd_ready), 1);
        feed(3, 32'h0, 0, 1'b0);
        collect("add", 1'b1, 8'h16, 1'b0, 1'b0, 0, 1'b0);

        // Subtract with borrow.
        ops[0] = 8'h07;
        start_job(8'h05, 1'b1, 1);
        feed(1, 32'h0, 0, 1'b0);
        collect("sub_borrow", 1'b1, 8'hFE, 1'b0, 1'b0, 0, 1'b0);

        // Wrap with carry.
        ops[0] = 8'h01;
        start_job(8'hFF, 1'b0, 1);
        feed(1, 32'h0, 0, 1'b0);
        collect("wrap", 1'b1, 8'h00, 1'b1, 1'b0, 0, 1'b0);

        // Sticky overflow.
        ops[0] = 8'h01; ops[1] = 8'hFF;
        start_job(8'h7F, 1'b0, 2);
        feed(2, 32'h0, 0, 1'b0);
        collect("sticky", 1'b1, 8'h7F, 1'b1, 1'b1, 0, 1'b0);

        ops[0] = 8'h01;
        start_job(8'h80, 1'b1, 1);
        feed(1, 32'h0, 0, 1'b0);
        collect("sub_ovr", 1'b1, 8'h7F, 1'b1, 1'b1, 0, 1'b0);

        // Zero-length job.
        start_job(8'hA5, 1'b1, 0);
        chk("cnt0_no_ready", int'(opnd_ready), 0);
        collect("cnt0", 1'b1, 8'hA5, 1'b0, 1'b0, 0, 1'b0);

        // Gapped operand stream, start glitches, result backpressure.
        ops[0] = 8'h10; ops[1] = 8'h20; ops[2] = 8'h30; ops[3] = 8'h08;
        start_job(8'h00, 1'b0, 4);
        feed(4, 32'h59, 7, 1'b1);
        collect("gapped", 1'b1, 8'h68, 1'b0, 1'b0, 3, 1'b1);

        // Asynchronous reset mid-job.
        ops[0] = 8'h11; ops[1] = 8'h22; ops[2] = 8'h33; ops[3] = 8'h44; ops[4] = 8'h55;
        start_job(8'h20, 1'b0, 5);
        feed(2, 32'h0, 0, 1'b0);
        opnd_valid = 1; opnd = 8'h77;
        #2;
        rst = 0;
        #1;
        chk("rst_busy",       int'(busy), 0);
        chk("rst_opnd_ready", int'(opnd_ready), 0);
        chk("rst_res_valid",  int'(res_valid), 0);
        chk("rst_result",     int'(result), 0);
        chk("rst_carry",      int'(carry), 0);
        chk("rst_ovr",        int'(ovr), 0);
        opnd_valid = 0;
        cycle();
        cycle();
        rst = 1;
        cycle();
        chk("post_rst_busy",      int'(busy), 0);
        chk("post_rst_res_valid", int'(res_valid), 0);

        ops[0] = 8'h10; ops[1] = 8'h50;
        start_job(8'h40, 1'b1, 2);
        feed(2, 32'h0, 0, 1'b0);
        collect("fresh", 1'b1, 8'hE0, 1'b0, 1'b0, 0, 1'b0);

        // Randomized traffic checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst = 0;
                cycle();
                rst = 1;
            end
            start  = ($urandom_range(0, 3) == 0);
            init   = 8'($urandom);
            op_sub = 1'($urandom);
            count  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                 : 4'($urandom_range(0, 4));
            opnd_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       opnd = 8'h7F;
                1:       opnd = 8'h80;
                2:       opnd = 8'hFF;
                default: opnd = 8'($urandom);
            endcase
            res_ready = 1'($urandom);
            cycle();
        end
        start = 0; opnd_valid = 0; res_ready = 0;
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
